// File: rtl/disp_sched.sv
// disp_sched: display scheduler for the LCD block viewer.
// Each request walks IDLE -> WAIT -> SHOW. IDLE captures the block number and
// launches the register-file or RAM read. WAIT holds the read address for
// RD_LAT cycles. SHOW registers the name/value pair and pulses display_valid.
// Handshake: display_valid is a one-cycle strobe with no ready. display_name
// and display_value are meaningful for the block captured in num_q while the
// strobe is high, and they hold that pair until the next strobe.
module disp_sched #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [5:0]  display_number,
    input  logic        input_valid,
    input  logic [31:0] input_value,
    input  logic [31:0] pc,
    input  logic        sort_over,
    output logic [4:0]  t_reg_addr,
    input  logic [31:0] t_reg_data,
    output logic [4:0]  t_ram_addr,
    input  logic [31:0] t_ram_data,
    output logic        display_valid,
    output logic [39:0] display_name,
    output logic [31:0] display_value
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_SHOW = 2'd2;

    // Value of wait_cnt on the last WAIT cycle.
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    logic [1:0]  state;
    logic [1:0]  wait_cnt;
    logic [5:0]  num_q;
    logic [4:0]  page;
    logic [31:0] cycle_cnt;

    logic        in_range;
    logic        is_reg;
    logic        is_ram;
    logic [4:0]  reg_idx;
    logic [4:0]  ram_idx;
    logic [39:0] show_name;
    logic [31:0] show_value;

    // Only the low five bits of the touch-screen value select the page.
    logic unused_bits;
    assign unused_bits = ^input_value[31:5];

    // Two ASCII hex digits for a 5-bit address: '0'/'1' then '0'..'F'.
    function automatic logic [15:0] hex2(input logic [4:0] a);
        logic [7:0] lo;
        lo = (a[3:0] < 4'd10) ? (8'h30 + {4'h0, a[3:0]}) : (8'h37 + {4'h0, a[3:0]});
        return {(a[4] ? 8'h31 : 8'h30), lo};
    endfunction

    // Decode the requested block and its read address. RAM addresses wrap mod 32.
    always_comb begin
        in_range = (display_number >= 6'd1) && (display_number <= 6'd44);
        is_reg   = (display_number >= 6'd3) && (display_number <= 6'd34);
        is_ram   = (display_number >= 6'd35) && (display_number <= 6'd44);
        reg_idx  = 5'(display_number - 6'd3);
        ram_idx  = page + 5'(display_number - 6'd35);
    end

    // Select the name/value pair for the captured block.
    always_comb begin
        show_name  = {"MEM", hex2(t_ram_addr)};
        show_value = t_ram_data;
        if (num_q == 6'd1) begin
            show_name  = "   PC";
            show_value = pc;
        end else if (num_q == 6'd2) begin
            show_name  = "CYCLE";
            show_value = cycle_cnt;
        end else if (num_q <= 6'd34) begin
            show_name  = {"REG", hex2(t_reg_addr)};
            show_value = t_reg_data;
        end
    end

    // Request FSM: capture, wait out read latency (abort on change), show.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            num_q         <= '0;
            t_reg_addr    <= '0;
            t_ram_addr    <= '0;
            display_valid <= 1'b0;
            display_name  <= '0;
            display_value <= '0;
        end else begin
            display_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    num_q    <= display_number;
                    wait_cnt <= '0;
                    if (in_range) begin
                        state <= ST_WAIT;
                        if (is_reg) begin
                            t_reg_addr <= reg_idx;
                        end else if (is_ram) begin
                            t_ram_addr <= ram_idx;
                        end
                    end
                end
                ST_WAIT: begin
                    if (display_number != num_q) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= ST_SHOW;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                ST_SHOW: begin
                    display_valid <= 1'b1;
                    display_name  <= show_name;
                    display_value <= show_value;
                    state         <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Page register follows the touch screen in every state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            page <= '0;
        end else if (input_valid) begin
            page <= input_value[4:0];
        end
    end

    // Run-time cycle counter: counts until the program finishes, saturating.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cycle_cnt <= '0;
        end else if (!sort_over && (cycle_cnt != 32'hFFFF_FFFF)) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_disp_sched.sv
// tb_disp_sched: two instances (RD_LAT=1 and RD_LAT=3) driven by the same
// directed stimulus. Each lane has a request-age model of the display rules and
// a latency-accurate register-file/RAM model; outputs are compared every cycle.
module tb_disp_sched;

  logic        clk;
  logic        resetn;
  logic [5:0]  display_number;
  logic        input_valid;
  logic [31:0] input_value;
  logic [31:0] pc;
  logic        sort_over;

  logic        dv_o   [2];
  logic [39:0] name_o [2];
  logic [31:0] val_o  [2];
  logic [4:0]  ra_o   [2];
  logic [4:0]  ma_o   [2];

  int n_cmp = 0;
  int n_bad = 0;
  int rel_cyc = 0;

  // strobe log per lane: count, first/last cycle, last name/value
  int          sc [2];
  int          fc [2];
  int          lc [2];
  logic [39:0] ln [2];
  logic [31:0] lv [2];

  logic [5:0] seq_dn [10] = '{6'd1, 6'd2, 6'd3, 6'd34, 6'd20, 6'd35, 6'd44, 6'd0, 6'd45, 6'd63};

  // clock / reset-relative cycle count
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rel_cyc <= resetn ? rel_cyc + 1 : 0;

  function automatic logic [31:0] reg_val(input logic [4:0] a);
    return 32'h1234_5671 + {27'd0, a};
  endfunction

  function automatic logic [31:0] ram_val(input logic [4:0] a);
    return 32'hC0DE_005A | ({27'd0, a} << 8);
  endfunction

  function automatic logic [39:0] exp_name(input logic [5:0] n, input logic [4:0] r, input logic [4:0] m);
    string hx;
    logic [4:0] a;
    hx = "0123456789ABCDEF";
    if (n == 6'd1) return "   PC";
    if (n == 6'd2) return "CYCLE";
    a = (n <= 6'd34) ? r : m;
    return {((n <= 6'd34) ? "REG" : "MEM"), ((a >= 5'd16) ? 8'h31 : 8'h30), hx.getc(int'(a % 5'd16))};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic clear_log();
    for (int k = 0; k < 2; k++) begin
      sc[k] = 0; fc[k] = 0; lc[k] = 0; ln[k] = '0; lv[k] = '0;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick(3);
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;

    logic [4:0]  rp [LAT];
    logic [4:0]  mp [LAT];
    logic [31:0] reg_d;
    logic [31:0] ram_d;

    disp_sched #(.RD_LAT(LAT)) u_dut (
      .clk            (clk),
      .resetn         (resetn),
      .display_number (display_number),
      .input_valid    (input_valid),
      .input_value    (input_value),
      .pc             (pc),
      .sort_over      (sort_over),
      .t_reg_addr     (ra_o[g]),
      .t_reg_data     (reg_d),
      .t_ram_addr     (ma_o[g]),
      .t_ram_data     (ram_d),
      .display_valid  (dv_o[g]),
      .display_name   (name_o[g]),
      .display_value  (val_o[g])
    );

    // synchronous memories with LAT cycles of read latency
    always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) begin
        rp[i] <= rp[i-1];
        mp[i] <= mp[i-1];
      end
      rp[0] <= ra_o[g];
      mp[0] <= ma_o[g];
    end
    assign reg_d = reg_val(rp[LAT-1]);
    assign ram_d = ram_val(mp[LAT-1]);

    // request-age model: a captured request is shown LAT+1 edges later unless
    // display_number moves off it during the LAT waiting edges
    logic        m_busy;
    int          m_age;
    logic [5:0]  m_num;
    logic [4:0]  m_reg, m_ram, m_page;
    logic [31:0] m_cyc;
    logic        m_dv;
    logic [39:0] m_name;
    logic [31:0] m_val;

    always @(posedge clk) begin
      if (!resetn) begin
        m_busy = 1'b0; m_age = 0; m_num = '0; m_reg = '0; m_ram = '0; m_page = '0;
        m_cyc = '0; m_dv = 1'b0; m_name = '0; m_val = '0;
      end else begin
        m_dv = 1'b0;
        if (!m_busy) begin
          m_num = display_number;
          if (display_number >= 1 && display_number <= 44) begin
            m_busy = 1'b1;
            m_age  = 0;
            if (display_number >= 3 && display_number <= 34) m_reg = 5'(display_number - 3);
            if (display_number >= 35) m_ram = 5'((m_page + display_number - 35) % 32);
          end
        end else begin
          m_age++;
          if (m_age <= LAT) begin
            if (display_number != m_num) m_busy = 1'b0;
          end else begin
            m_dv   = 1'b1;
            m_name = exp_name(m_num, m_reg, m_ram);
            if (m_num == 1) m_val = pc;
            else if (m_num == 2) m_val = m_cyc;
            else if (m_num <= 34) m_val = reg_val(m_reg);
            else m_val = ram_val(m_ram);
            m_busy = 1'b0;
          end
        end
        if (input_valid) m_page = input_value[4:0];
        if (!sort_over && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
      end
    end

    // compare every cycle, and log strobes for the directed checks
    always @(negedge clk) begin
      chk($sformatf("lane%0d display_valid", g), 64'(dv_o[g]), 64'(m_dv));
      chk($sformatf("lane%0d display_name", g), 64'(name_o[g]), 64'(m_name));
      chk($sformatf("lane%0d display_value", g), 64'(val_o[g]), 64'(m_val));
      chk($sformatf("lane%0d t_reg_addr", g), 64'(ra_o[g]), 64'(m_reg));
      chk($sformatf("lane%0d t_ram_addr", g), 64'(ma_o[g]), 64'(m_ram));
      if (dv_o[g] === 1'b1) begin
        sc[g]++;
        if (fc[g] == 0) fc[g] = rel_cyc;
        lc[g] = rel_cyc;
        ln[g] = name_o[g];
        lv[g] = val_o[g];
      end
    end
  end

  initial begin
    resetn = 1'b0; display_number = 6'd10; input_valid = 1'b0; input_value = '0;
    pc = 32'h0000_1000; sort_over = 1'b1;
    clear_log();
    tick(3);
    for (int k = 0; k < 2; k++) begin
      chk("reset display_valid", 64'(dv_o[k]), 64'd0);
      chk("reset display_name", 64'(name_o[k]), 64'd0);
      chk("reset display_value", 64'(val_o[k]), 64'd0);
      chk("reset t_reg_addr", 64'(ra_o[k]), 64'd0);
      chk("reset t_ram_addr", 64'(ma_o[k]), 64'd0);
    end

    // block 10 held: REG07 every RD_LAT+2 cycles
    resetn = 1'b1;
    tick(9);
    chk("blk10 strobe count", 64'(sc[0]), 64'd3);
    chk("blk10 first strobe cycle", 64'(fc[0]), 64'd3);
    chk("blk10 last strobe cycle", 64'(lc[0]), 64'd9);
    chk("blk10 name", 64'(ln[0]), 64'("REG07"));
    chk("blk10 value", 64'(lv[0]), 64'h1234_5678);
    chk("blk10 t_reg_addr", 64'(ra_o[0]), 64'd7);
    chk("blk10 lat3 first strobe cycle", 64'(fc[1]), 64'd5);

    // page 30 + block 37 wraps to RAM word 0; block 44 -> word 7
    input_valid = 1'b1; input_value = 32'd30;
    tick(1);
    input_valid = 1'b0; display_number = 6'd37;
    tick(6); clear_log(); tick(10);
    chk("page wrap t_ram_addr", 64'(ma_o[0]), 64'd0);
    chk("page wrap name", 64'(ln[0]), 64'("MEM00"));
    chk("page wrap value", 64'(lv[0]), 64'hC0DE_005A);
    chk("page wrap lat3 name", 64'(ln[1]), 64'("MEM00"));
    display_number = 6'd44;
    tick(6); clear_log(); tick(10);
    chk("blk44 name", 64'(ln[0]), 64'("MEM07"));
    chk("blk44 value", 64'(lv[0]), 64'hC0DE_075A);

    // RD_LAT=3: 10 -> 11 during WAIT aborts, next strobe is REG08
    display_number = 6'd10;
    do_reset(); clear_log();
    resetn = 1'b1;
    tick(2);
    display_number = 6'd11;
    tick(8);
    chk("abort lat3 strobe count", 64'(sc[1]), 64'd1);
    chk("abort lat3 strobe cycle", 64'(fc[1]), 64'd8);
    chk("abort lat3 name", 64'(ln[1]), 64'("REG08"));
    chk("abort lat3 value", 64'(lv[1]), 64'h1234_5679);

    // out-of-range blocks never strobe
    display_number = 6'd0;
    tick(6); clear_log(); tick(20);
    chk("blk0 strobes lat1", 64'(sc[0]), 64'd0);
    chk("blk0 strobes lat3", 64'(sc[1]), 64'd0);
    display_number = 6'd50;
    tick(6); clear_log(); tick(20);
    chk("blk50 strobes lat1", 64'(sc[0]), 64'd0);
    chk("blk50 strobes lat3", 64'(sc[1]), 64'd0);

    // cycle counter: 100 running cycles, then frozen
    display_number = 6'd2; sort_over = 1'b0;
    do_reset();
    resetn = 1'b1;
    tick(100);
    sort_over = 1'b1;
    tick(1); clear_log(); tick(15);
    chk("cycle name", 64'(ln[0]), 64'("CYCLE"));
    chk("cycle value lat1", 64'(lv[0]), 64'd100);
    chk("cycle value lat3", 64'(lv[1]), 64'd100);
    chk("cycle strobes lat1", 64'(sc[0]), 64'd5);
    chk("cycle strobes lat3", 64'(sc[1]), 64'd3);

    // PC block
    display_number = 6'd1; pc = 32'hDEAD_BEEF;
    tick(6); clear_log(); tick(6);
    chk("pc name", 64'(ln[0]), 64'("   PC"));
    chk("pc value", 64'(lv[0]), 64'hDEAD_BEEF);

    // reset in the middle of WAIT
    display_number = 6'd10;
    do_reset(); clear_log();
    resetn = 1'b1;
    tick(2);
    resetn = 1'b0;
    tick(1);
    for (int k = 0; k < 2; k++) begin
      chk("mid-wait reset display_valid", 64'(dv_o[k]), 64'd0);
      chk("mid-wait reset display_name", 64'(name_o[k]), 64'd0);
      chk("mid-wait reset display_value", 64'(val_o[k]), 64'd0);
      chk("mid-wait reset t_reg_addr", 64'(ra_o[k]), 64'd0);
      chk("mid-wait reset t_ram_addr", 64'(ma_o[k]), 64'd0);
    end
    tick(4);
    chk("mid-wait reset strobes lat1", 64'(sc[0]), 64'd0);
    chk("mid-wait reset strobes lat3", 64'(sc[1]), 64'd0);

    // sweep of blocks with page changes during WAIT, checked by the model
    resetn = 1'b1; sort_over = 1'b0;
    for (int i = 0; i < 10; i++) begin
      display_number = seq_dn[i];
      pc = 32'h0040_0000 + 32'(i * 4);
      sort_over = (i % 2 == 1);
      input_valid = 1'b1; input_value = 32'(i * 7 + 3);
      tick(1);
      input_valid = 1'b0;
      tick(3);
      input_valid = 1'b1; input_value = 32'(i * 5);
      tick(1);
      input_valid = 1'b0;
      tick(5);
    end
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/disp_sched.md
DISP_SCHED -- requirements
Module: disp_sched

Interface
REQ-001 SHALL have parameter: RD_LAT, 1, read latency in cycles of the register-file and RAM read ports; legal range 1..3.
REQ-002 SHALL have port: clk  in  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port: resetn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: display_number  in  6  block index 1..44 currently requested by lcd_module.
REQ-005 SHALL have port: input_valid  in  1  touch-screen value strobe.
REQ-006 SHALL have port: input_value  in  32  touch-screen value.
REQ-007 SHALL have port: pc  in  32  CPU program counter.
REQ-008 SHALL have port: sort_over  in  1  program-finished flag.
REQ-009 SHALL have port: t_reg_addr  out  5  register-file read address.
REQ-010 SHALL have port: t_reg_data  in  32  register-file read data, valid RD_LAT cycles after address.
REQ-011 SHALL have port: t_ram_addr  out  5  data-RAM read address.
REQ-012 SHALL have port: t_ram_data  in  32  data-RAM read data, valid RD_LAT cycles after address.
REQ-013 SHALL have port: display_valid  out  1  one-cycle strobe; name/value valid for display_number.
REQ-014 SHALL have port: display_name  out  40  5 ASCII characters.
REQ-015 SHALL have port: display_value  out  32  value shown.

Function
REQ-016 SHALL map blocks: 1 = PC (name "   PC", value pc); 2 = cycle counter (name "CYCLE"); 3..34 = register n-3 (name "REG"+2 hex chars); 35..44 = RAM word (page+n-35) mod 32 (name "MEM"+2 hex chars).
REQ-017 SHALL encode hex chars: name[15:8] = "0"/"1" from addr[4]; name[7:0] = "0".."9","A".."F" from addr[3:0].
REQ-018 SHALL implement FSM IDLE -> WAIT -> SHOW -> IDLE.
REQ-019 IDLE: SHALL capture num_q <= display_number; SHALL drive t_reg_addr/t_ram_addr for the captured block; SHALL go to WAIT if 1<=display_number<=44, otherwise stay in IDLE with display_valid=0.
REQ-020 WAIT: SHALL hold addresses stable and count RD_LAT cycles, then go to SHOW.
REQ-021 SHOW: SHALL register name/value from the source selected by num_q and pulse display_valid=1 for exactly one cycle, then go to IDLE.
REQ-022 Blocks 1 and 2 SHALL traverse WAIT like other blocks so that latency is uniform.
REQ-023 Latency SHALL be RD_LAT+2 cycles from display_number sampled in IDLE to display_valid high.
REQ-024 If display_number != num_q during WAIT, SHALL abort without a display_valid strobe and go to IDLE.
REQ-025 Page register (5 bit) SHALL load input_value[4:0] on input_valid in any state, with no effect on the FSM.
REQ-026 RAM address SHALL be computed from page at IDLE capture and held through WAIT; a page change during WAIT SHALL affect only the next read.
REQ-027 RAM address arithmetic SHALL be 5-bit modulo 32 (page 30, block 37 -> address 0).
REQ-028 Cycle counter SHALL be 32 bit, increment every cycle while sort_over=0, hold while sort_over=1, and saturate at 0xFFFFFFFF.
REQ-029 When the address port is unused, t_reg_addr and t_ram_addr SHALL hold their last value.
REQ-030 display_name and display_value SHALL change only in SHOW.

Reset
REQ-031 With resetn=0 at a clk edge, the block SHALL go to state IDLE and clear display_valid, display_name, display_value, t_reg_addr, t_ram_addr, page, cycle counter and num_q to 0.
REQ-032 Reset mid-WAIT or mid-SHOW SHALL suppress any pending strobe.
REQ-033 The first read SHALL start in the cycle after resetn=1.

Verification
REQ-034 Bench SHALL check: RD_LAT=1, display_number=10 held, t_reg_data=0x12345678 -> t_reg_addr=7; display_valid at cycle 3; name "REG07"; value 0x12345678; repeats every 3 cycles.
REQ-035 Bench SHALL check: input_valid with input_value=30, display_number=37 -> t_ram_addr=0, name "MEM00".
REQ-036 Bench SHALL check: RD_LAT=3, display_number changed 10->11 during WAIT -> no strobe for 10; next strobe is "REG08".
REQ-037 Bench SHALL check: display_number=0 or 50 -> display_valid stays 0 indefinitely.
REQ-038 Bench SHALL check: sort_over=0 for 100 cycles after reset, then 1 -> block 2 shows 100 and stays constant.
REQ-039 Bench SHALL check: resetn=0 asserted during WAIT -> all outputs 0 next cycle and no display_valid pulse.
